uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 33 +++
 rtl/uart_fifo.sv | 58 +++++
 rtl/uart_tx.sv | 114 +++++++++++
 tb/tb_uart_tx.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants for the UART transmitter.
//   UART_ADDR      : CPU store address that decodes to the UART data register
//   ST_*           : bit positions inside the 32-bit status word
//   tx_state_e     : transmitter FSM encoding
//   pack_status()  : builds the status word from its flag bits
package uart_tx_pkg;

  localparam logic [31:0] UART_ADDR = 32'h8000_0010;

  localparam int ST_BUSY  = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(input logic busy, input logic full,
                                              input logic empty, input logic ovf);
    logic [31:0] s;
    s           = '0;
    s[ST_BUSY]  = busy;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: byte FIFO feeding the transmitter.
//   clk, rst : system clock, synchronous active-high reset
//   push/din : write strobe and byte; accepted when not full, or when full
//              but a pop happens in the same cycle
//   pop      : remove head (ignored when empty)
//   dout     : current head byte (valid while !empty)
//   full     : count == DEPTH
//   empty    : count == 0
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A slot freed by a same-cycle pop can take the incoming byte.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//   clk     : system clock (rising edge)
//   rst     : synchronous active-high reset; aborts any frame in flight
//   we      : store strobe, already decoded for UART_ADDR
//   wr_data : byte to send
//   txd     : registered serial line, idle high
//   status  : registered {28'b0, overflow, empty, full, busy}, one cycle
//             behind the FSM/FIFO state to line up with the load writeback
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [7:0]  wr_data,
  output logic        txd,
  output logic [31:0] status
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          ovf;

  logic       bit_end, pop, push;
  logic [7:0] head;
  logic       fifo_full, fifo_empty;

  assign bit_end = (bit_cnt == LAST);
  // Pop from IDLE, or at the very end of a stop bit so the next start bit
  // follows with no idle gap.
  assign pop  = !rst && !fifo_empty &&
                ((state == IDLE) || ((state == STOP) && bit_end));
  assign push = we && !rst;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (wr_data),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      txd     <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      ovf     <= 1'b0;
      status  <= pack_status(1'b0, 1'b0, 1'b1, 1'b0);
    end else begin
      status <= pack_status((state != IDLE) || !fifo_empty, fifo_full, fifo_empty, ovf);
      // Dropped write: full and no pop to make room this cycle.
      if (we && fifo_full && !pop) ovf <= 1'b1;

      bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;

      case (state)
        IDLE: begin
          bit_cnt <= '0;
          if (pop) begin
            shreg <= head;
            txd   <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            txd     <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg <= head;
              txd   <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [7:0]  wr_data;
  logic        txd;
  logic [31:0] status;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int s1, s2, s3;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .wr_data (wr_data),
    .txd     (txd),
    .status  (status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  d;
    logic [9:0]  frame;   // index 0 = start bit, index 9 = stop bit
    logic [31:0] st_e1;   // status one cycle after the write edge
    logic [31:0] st_end;  // status after the frame completes
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Waits (bounded) for a start bit, then samples all 40 cycles of the frame.
  task automatic expect_frame(input logic [9:0] frame, input string name, output int start);
    int t = 0;
    int glitch = 0;
    logic [9:0] got = '0;
    start = -1;
    while (txd !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (txd !== 1'b0) begin
      chk({name, " start_timeout"}, 32'(txd), 32'd0);
      return;
    end
    start = cyc;
    for (int k = 0; k < 40; k++) begin
      if (k % 4 == 0) got[k/4] = txd;
      else if (txd !== got[k/4]) glitch++;
      @(negedge clk);
    end
    chk({name, " frame"}, {glitch[21:0], got}, {22'd0, frame});
  endtask

  task automatic write_byte(input logic [7:0] d);
    we = 1'b1;
    wr_data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset status", status, 32'h4);
  endtask

  initial begin
    int st;
    int lows;
    int bad_st;

    tbl[0] = '{8'hA5, 10'b1101001010, 32'h1, 32'h4};
    tbl[1] = '{8'h00, 10'b1000000000, 32'h1, 32'h4};
    tbl[2] = '{8'hFF, 10'b1111111110, 32'h1, 32'h4};
    tbl[3] = '{8'h01, 10'b1000000010, 32'h1, 32'h4};
    tbl[4] = '{8'h80, 10'b1100000000, 32'h1, 32'h4};
    tbl[5] = '{8'h3C, 10'b1001111000, 32'h1, 32'h4};

    rst = 1'b1;
    we = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset txd", 32'(txd), 32'd1);
    chk("reset status", status, 32'h4);
    @(negedge clk);
    chk("idle status", status, 32'h4);

    // Single writes from idle: latency, bit timing, status around the frame.
    for (int i = 0; i < 6; i++) begin
      write_byte(tbl[i].d);
      chk($sformatf("lat_hi %02h", tbl[i].d), 32'(txd), 32'd1);
      @(negedge clk);
      chk($sformatf("lat_lo %02h", tbl[i].d), 32'(txd), 32'd0);
      chk($sformatf("st_e1 %02h", tbl[i].d), status, tbl[i].st_e1);
      expect_frame(tbl[i].frame, $sformatf("tbl %02h", tbl[i].d), st);
      @(negedge clk);
      chk($sformatf("st_end %02h", tbl[i].d), status, tbl[i].st_end);
      chk($sformatf("idle_txd %02h", tbl[i].d), 32'(txd), 32'd1);
    end

    // Three consecutive writes -> three frames with no gap.
    fork
      begin
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
      end
      begin
        expect_frame({1'b1, 8'h01, 1'b0}, "b2b 01", s1);
        expect_frame({1'b1, 8'h02, 1'b0}, "b2b 02", s2);
        expect_frame({1'b1, 8'h03, 1'b0}, "b2b 03", s3);
      end
    join
    chk("b2b gap", 32'(s2 - s1), 32'd40);
    chk("b2b total", 32'(s3 + 40 - s1), 32'd120);
    @(negedge clk);
    chk("b2b st_end", status, 32'h4);

    // Six writes while idle: one popped, four queued, sixth dropped.
    fork
      begin
        for (int i = 0; i < 6; i++) write_byte(8'h10 + 8'(i));
        chk("ovf pre", status, 32'h3);
        @(negedge clk);
        chk("ovf set", status, 32'hB);
      end
      begin
        for (int i = 0; i < 5; i++)
          expect_frame({1'b1, 8'h10 + 8'(i), 1'b0}, $sformatf("ovf %0d", i), st);
      end
    join
    @(negedge clk);
    chk("ovf sticky", status, 32'hC);
    chk("ovf no 6th", 32'(txd), 32'd1);
    do_reset();

    // Full FIFO, write lands on the STOP->START pop edge.
    fork
      begin
        for (int i = 0; i < 5; i++) write_byte(8'h20 + 8'(i));
        repeat (36) @(negedge clk);
        write_byte(8'h25);
        chk("fullpop pre", status, 32'h3);
        @(negedge clk);
        chk("fullpop cnt", status, 32'h3);
      end
      begin
        for (int i = 0; i < 6; i++)
          expect_frame({1'b1, 8'h20 + 8'(i), 1'b0}, $sformatf("fullpop %0d", i), st);
      end
    join
    @(negedge clk);
    chk("fullpop end", status, 32'h4);

    // Reset during data bit 3 with two bytes queued.
    write_byte(8'h30);
    write_byte(8'h31);
    write_byte(8'h32);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst txd", 32'(txd), 32'd1);
    chk("midrst status", status, 32'h4);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 150; k++) begin
      if (txd !== 1'b1) lows++;
      @(negedge clk);
    end
    chk("midrst no resume", 32'(lows), 32'd0);
    chk("midrst status end", status, 32'h4);

    // Write while reset is high is ignored.
    rst = 1'b1;
    we = 1'b1;
    wr_data = 8'h55;
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    lows = 0;
    bad_st = 0;
    for (int k = 0; k < 60; k++) begin
      if (txd !== 1'b1) lows++;
      if (status !== 32'h4) bad_st++;
      @(negedge clk);
    end
    chk("rstwr no tx", 32'(lows), 32'd0);
    chk("rstwr status", 32'(bad_st), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
